// File: rtl/tile_ring_input_buf_pkg.sv
// Shared types and geometry for the tile ring input buffer.
package tile_ring_pkg;

    localparam int N_ROWS     = 7;    // MLP rows per tile
    localparam int K_MAX      = 384;  // bytes per MLP row
    localparam int N_PE       = 12;   // PE columns on the output bus
    localparam int N_WIN      = 7;    // windows per PE (must not exceed N_ROWS)
    localparam int N_TAP      = 4;    // bytes per window
    localparam int N_BANK     = 2;    // banks in the ring, 2..4

    localparam int BANK_BYTES = N_ROWS * K_MAX;
    localparam int AW         = $clog2(BANK_BYTES / 4);
    localparam int BA_W       = $clog2(BANK_BYTES);
    localparam int OUT_BYTES  = N_PE * N_WIN * N_TAP;
    localparam int COL_W      = $clog2(K_MAX);
    localparam int PTR_W      = (N_BANK > 1) ? $clog2(N_BANK) : 1;
    localparam int CNT_W      = $clog2(N_BANK + 1);

    typedef enum logic [1:0] {FREE, FILL, FULL, READ} bank_state_e;
    typedef enum logic       {CONV, MLP}              layout_e;

    typedef logic [PTR_W-1:0] ptr_t;

    // Ring pointers wrap at N_BANK, which need not be a power of two.
    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == ptr_t'(N_BANK - 1)) ? '0 : ptr_t'(p + 1'b1);
    endfunction

    // Reduction index of an MLP lane for a given sub-cycle.
    function automatic int mlp_k(logic [2:0] sub, int pe, int tap);
        return int'(sub) * N_PE * N_TAP + pe * N_TAP + tap;
    endfunction

endpackage

// File: rtl/tile_ring_input_buf_if.sv
// Producer/consumer bus of the tile ring input buffer.
//
// Handshake: a load word transfers on every cycle where ld_valid && ld_ready;
// ld_ready comes only from registered bank state, so it never depends on
// ld_valid. cap_en, wr_commit, rd_start, rd_req and rd_release are one-cycle
// strobes with no back-pressure; strobes that find no eligible bank are
// dropped (write side raises err_overrun, rd_req raises err_underrun).
// out_valid is a one-cycle pulse one cycle after an accepted rd_req.
interface tile_ring_input_buf_if;
    import tile_ring_pkg::*;

    logic                     mode;
    logic                     ld_valid;
    logic                     ld_ready;
    logic [AW-1:0]            ld_addr;
    logic [31:0]              ld_data;
    logic [3:0]               ld_be;
    logic                     cap_en;
    logic [COL_W-1:0]         cap_col;
    logic [N_ROWS*8-1:0]      cap_data;
    logic                     wr_commit;
    logic                     rd_start;
    logic                     rd_req;
    logic [2:0]               rd_sub_cycle;
    logic                     rd_release;
    logic                     rd_active;
    logic [OUT_BYTES*8-1:0]   data_out;
    logic                     out_valid;
    logic [CNT_W-1:0]         full_cnt;
    logic                     err_overrun;
    logic                     err_underrun;
    logic [2*N_BANK-1:0]      dbg_state;    // bank i state at [2i+:2]

    modport master (
        output mode, ld_valid, ld_addr, ld_data, ld_be,
               cap_en, cap_col, cap_data, wr_commit,
               rd_start, rd_req, rd_sub_cycle, rd_release,
        input  ld_ready, rd_active, data_out, out_valid, full_cnt,
               err_overrun, err_underrun, dbg_state
    );

    modport slave (
        input  mode, ld_valid, ld_addr, ld_data, ld_be,
               cap_en, cap_col, cap_data, wr_commit,
               rd_start, rd_req, rd_sub_cycle, rd_release,
        output ld_ready, rd_active, data_out, out_valid, full_cnt,
               err_overrun, err_underrun, dbg_state
    );

endinterface

// File: rtl/tile_ring_input_buf_bank_ram.sv
// One tile bank: byte-enabled word writes, strided MLP column capture,
// and a combinational full-width operand read in conv or MLP layout.
module tile_bank_ram
    import tile_ring_pkg::*;
(
    input  logic                    clk,
    input  logic                    ld_we_i,
    input  logic [AW-1:0]           ld_addr_i,
    input  logic [31:0]             ld_data_i,
    input  logic [3:0]              ld_be_i,
    input  logic                    cap_we_i,
    input  logic [COL_W-1:0]        cap_col_i,
    input  logic [N_ROWS*8-1:0]     cap_data_i,
    input  layout_e                 layout_i,
    input  logic [2:0]              rd_sub_i,
    output logic [OUT_BYTES*8-1:0]  rd_data_o
);

    logic [7:0] mem_q [BANK_BYTES];

    // Storage writes; capture is applied last so it wins a byte collision.
    always_ff @(posedge clk) begin
        if (ld_we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (ld_be_i[b] && (int'({ld_addr_i, 2'(b)}) < BANK_BYTES)) begin
                    mem_q[BA_W'({ld_addr_i, 2'(b)})] <= ld_data_i[8*b +: 8];
                end
            end
        end
        if (cap_we_i && (int'(cap_col_i) < K_MAX)) begin
            for (int r = 0; r < N_ROWS; r++) begin
                mem_q[BA_W'(r * K_MAX + int'(cap_col_i))] <= cap_data_i[8*r +: 8];
            end
        end
    end

    // Operand view: conv is a linear sweep, MLP takes a k-slice of every row.
    always_comb begin
        rd_data_o = '0;
        for (int pe = 0; pe < N_PE; pe++) begin
            for (int win = 0; win < N_WIN; win++) begin
                for (int tap = 0; tap < N_TAP; tap++) begin
                    if (layout_i == CONV) begin
                        if ((pe * N_WIN + win) * N_TAP + tap < BANK_BYTES) begin
                            rd_data_o[8*((pe*N_WIN+win)*N_TAP+tap) +: 8] =
                                mem_q[BA_W'((pe * N_WIN + win) * N_TAP + tap)];
                        end
                    end else begin
                        if (mlp_k(rd_sub_i, pe, tap) < K_MAX) begin
                            rd_data_o[8*((pe*N_WIN+win)*N_TAP+tap) +: 8] =
                                mem_q[BA_W'(win * K_MAX + mlp_k(rd_sub_i, pe, tap))];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tile_ring_input_buf.sv
// Ring of tile banks: the producer fills and commits banks at fill_ptr, the
// consumer acquires, sweeps and releases them in order at rd_ptr. Each bank
// remembers the layout it was committed with.
module tile_ring_input_buf
    import tile_ring_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    tile_ring_input_buf_if.slave bus
);

    bank_state_e              state_q [N_BANK];
    bank_state_e              state_d [N_BANK];
    layout_e                  mode_q  [N_BANK];
    layout_e                  mode_d  [N_BANK];
    ptr_t                     fill_ptr_q, fill_ptr_d;
    ptr_t                     rd_ptr_q,   rd_ptr_d;
    logic                     out_valid_q, out_valid_d;
    logic [OUT_BYTES*8-1:0]   data_q, data_d;
    logic                     err_ov_q, err_ov_d;
    logic                     err_un_q, err_un_d;

    logic                     writable;
    logic                     rd_active;
    logic                     ld_acc;
    logic                     cap_acc;
    logic [CNT_W-1:0]         full_cnt;
    logic [2*N_BANK-1:0]      dbg_state;
    logic [OUT_BYTES*8-1:0]   bank_rd [N_BANK];

    for (genvar g = 0; g < N_BANK; g++) begin : g_bank
        tile_bank_ram u_ram (
            .clk        (clk),
            .ld_we_i    (ld_acc && (fill_ptr_q == ptr_t'(g))),
            .ld_addr_i  (bus.ld_addr),
            .ld_data_i  (bus.ld_data),
            .ld_be_i    (bus.ld_be),
            .cap_we_i   (cap_acc && (fill_ptr_q == ptr_t'(g))),
            .cap_col_i  (bus.cap_col),
            .cap_data_i (bus.cap_data),
            .layout_i   (mode_q[g]),
            .rd_sub_i   (bus.rd_sub_cycle),
            .rd_data_o  (bank_rd[g])
        );
    end

    // State register: bank FSMs, pointers, sticky errors and the output latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BANK; i++) begin
                state_q[i] <= FREE;
                mode_q[i]  <= CONV;
            end
            fill_ptr_q  <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            err_ov_q    <= 1'b0;
            err_un_q    <= 1'b0;
        end else begin
            for (int i = 0; i < N_BANK; i++) begin
                state_q[i] <= state_d[i];
                mode_q[i]  <= mode_d[i];
            end
            fill_ptr_q  <= fill_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            err_ov_q    <= err_ov_d;
            err_un_q    <= err_un_d;
        end
    end

    // Next state: producer side acts on the fill bank, consumer side on the
    // read bank; both decisions use the registered (pre-edge) bank states.
    always_comb begin
        for (int i = 0; i < N_BANK; i++) begin
            state_d[i] = state_q[i];
            mode_d[i]  = mode_q[i];
        end
        fill_ptr_d  = fill_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = 1'b0;
        data_d      = data_q;
        err_ov_d    = err_ov_q;
        err_un_d    = err_un_q;

        if (writable) begin
            if (bus.wr_commit) begin
                state_d[fill_ptr_q] = FULL;
                mode_d[fill_ptr_q]  = layout_e'(bus.mode);
                fill_ptr_d          = ptr_inc(fill_ptr_q);
            end else if ((ld_acc || cap_acc) && (state_q[fill_ptr_q] == FREE)) begin
                state_d[fill_ptr_q] = FILL;
            end
        end else if (bus.ld_valid || bus.cap_en || bus.wr_commit) begin
            err_ov_d = 1'b1;
        end

        if (bus.rd_start && !rd_active && (state_q[rd_ptr_q] == FULL)) begin
            state_d[rd_ptr_q] = READ;
        end

        if (bus.rd_req) begin
            if (rd_active) begin
                out_valid_d = 1'b1;
                data_d      = bank_rd[rd_ptr_q];
            end else begin
                err_un_d = 1'b1;
            end
        end

        if (bus.rd_release && rd_active) begin
            state_d[rd_ptr_q] = FREE;
            rd_ptr_d          = ptr_inc(rd_ptr_q);
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        writable  = (state_q[fill_ptr_q] == FREE) || (state_q[fill_ptr_q] == FILL);
        rd_active = (state_q[rd_ptr_q] == READ);
        ld_acc    = bus.ld_valid && writable;
        cap_acc   = bus.cap_en && writable;
        full_cnt  = '0;
        dbg_state = '0;
        for (int i = 0; i < N_BANK; i++) begin
            if (state_q[i] == FULL) begin
                full_cnt = full_cnt + CNT_W'(1);
            end
            dbg_state[2*i +: 2] = state_q[i];
        end
    end

    assign bus.ld_ready     = writable;
    assign bus.rd_active    = rd_active;
    assign bus.full_cnt     = full_cnt;
    assign bus.dbg_state    = dbg_state;
    assign bus.out_valid    = out_valid_q;
    assign bus.data_out     = data_q;
    assign bus.err_overrun  = err_ov_q;
    assign bus.err_underrun = err_un_q;

endmodule

// File: tb/tb_tile_ring_input_buf.sv
// Bench for tile_ring_input_buf: a behavioural bank model predicts every
// read, expected words are queued when rd_req is driven and compared when
// out_valid appears.
module tb_tile_ring_input_buf;
  import tile_ring_pkg::*;

  localparam int OUT_BITS = OUT_BYTES * 8;
  localparam int N_CHUNK  = OUT_BITS / 128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tile_ring_input_buf_if bus();

  tile_ring_input_buf dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [OUT_BITS-1:0] exp_q[$];

  logic [7:0]  m_mem   [N_BANK][BANK_BYTES];
  bank_state_e m_state [N_BANK];
  layout_e     m_mode  [N_BANK];
  int          m_fill;
  int          m_rd;
  logic        m_ov;
  logic        m_un;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_writable();
    return (m_state[m_fill] == FREE) || (m_state[m_fill] == FILL);
  endfunction

  function automatic int m_full_cnt();
    int n = 0;
    for (int i = 0; i < N_BANK; i++) if (m_state[i] == FULL) n++;
    return n;
  endfunction

  function automatic logic [OUT_BITS-1:0] exp_read(int b, logic [2:0] sub);
    logic [OUT_BITS-1:0] r;
    int lane;
    int k;
    r = '0;
    for (int pe = 0; pe < N_PE; pe++)
      for (int win = 0; win < N_WIN; win++)
        for (int tap = 0; tap < N_TAP; tap++) begin
          lane = (pe * N_WIN + win) * N_TAP + tap;
          if (m_mode[b] == CONV) begin
            if (lane < BANK_BYTES) r[8*lane +: 8] = m_mem[b][lane];
          end else begin
            k = int'(sub) * N_PE * N_TAP + pe * N_TAP + tap;
            if (k < K_MAX) r[8*lane +: 8] = m_mem[b][win * K_MAX + k];
          end
        end
    return r;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N_BANK; i++) begin
      m_state[i] = FREE;
      m_mode[i]  = CONV;
    end
    m_fill = 0;
    m_rd   = 0;
    m_ov   = 1'b0;
    m_un   = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_pulses();
    bus.ld_valid   = 1'b0;
    bus.cap_en     = 1'b0;
    bus.wr_commit  = 1'b0;
    bus.rd_start   = 1'b0;
    bus.rd_req     = 1'b0;
    bus.rd_release = 1'b0;
  endtask

  // Apply whatever the caller set up for one clock, updating the model.
  task automatic step();
    bank_state_e ps [N_BANK];
    logic wr_ok;
    logic act;
    int idx;
    ps    = m_state;
    wr_ok = (ps[m_fill] == FREE) || (ps[m_fill] == FILL);
    act   = (ps[m_rd] == READ);
    if (bus.rd_req) begin
      if (act) exp_q.push_back(exp_read(m_rd, bus.rd_sub_cycle));
      else m_un = 1'b1;
    end
    if (wr_ok) begin
      if (bus.ld_valid)
        for (int b = 0; b < 4; b++)
          if (bus.ld_be[b]) begin
            idx = int'(bus.ld_addr) * 4 + b;
            if (idx < BANK_BYTES) m_mem[m_fill][idx] = bus.ld_data[8*b +: 8];
          end
      if (bus.cap_en && int'(bus.cap_col) < K_MAX)
        for (int r = 0; r < N_ROWS; r++)
          m_mem[m_fill][r * K_MAX + int'(bus.cap_col)] = bus.cap_data[8*r +: 8];
      if (bus.wr_commit) begin
        m_state[m_fill] = FULL;
        m_mode[m_fill]  = layout_e'(bus.mode);
        m_fill          = (m_fill + 1) % N_BANK;
      end else if ((bus.ld_valid || bus.cap_en) && ps[m_fill] == FREE) begin
        m_state[m_fill] = FILL;
      end
    end else if (bus.ld_valid || bus.cap_en || bus.wr_commit) begin
      m_ov = 1'b1;
    end
    if (bus.rd_start && !act && ps[m_rd] == FULL) m_state[m_rd] = READ;
    if (bus.rd_release && act) begin
      m_state[m_rd] = FREE;
      m_rd          = (m_rd + 1) % N_BANK;
    end
    @(negedge clk);
    clear_pulses();
  endtask

  task automatic ld_word(int addr, logic [31:0] d, logic [3:0] be);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = AW'(addr);
    bus.ld_data  = d;
    bus.ld_be    = be;
    step();
  endtask

  task automatic commit(logic md);
    bus.mode      = md;
    bus.wr_commit = 1'b1;
    step();
  endtask

  task automatic rd_start();
    bus.rd_start = 1'b1;
    step();
  endtask

  task automatic rd_req(int sub);
    bus.rd_req       = 1'b1;
    bus.rd_sub_cycle = 3'(sub);
    step();
  endtask

  task automatic rd_release();
    bus.rd_release = 1'b1;
    step();
  endtask

  task automatic check_status(string tag);
    chk({tag, "_ld_ready"},  bus.ld_ready,     m_writable());
    chk({tag, "_rd_active"}, bus.rd_active,    m_state[m_rd] == READ);
    chk({tag, "_full_cnt"},  bus.full_cnt,     m_full_cnt());
    chk({tag, "_overrun"},   bus.err_overrun,  m_ov);
    chk({tag, "_underrun"},  bus.err_underrun, m_un);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_valid", 1, 0);
      end else begin
        logic [OUT_BITS-1:0] e;
        e = exp_q.pop_front();
        for (int c = 0; c < N_CHUNK; c++)
          chk($sformatf("sb_data_chunk%0d", c), bus.data_out[128*c +: 128], e[128*c +: 128]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [OUT_BITS-1:0] held;
    logic [7:0] old1;
    logic [7:0] old3;
    logic [N_ROWS*8-1:0] cd;

    rst_n = 1'b0;
    bus.mode = 1'b0;
    bus.ld_addr = '0;
    bus.ld_data = '0;
    bus.ld_be = '0;
    bus.cap_col = '0;
    bus.cap_data = '0;
    bus.rd_sub_cycle = '0;
    clear_pulses();
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check_status("reset");
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_data_out", bus.data_out[127:0], 0);
    chk("reset_dbg_state", bus.dbg_state, 0);

    // 1: conv layout, bank 0
    for (int i = 0; i < 84; i++)
      ld_word(i, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 4'hF);
    commit(1'b0);
    rd_start();
    check_status("t1_started");
    rd_req(3);
    chk("t1_out_valid", bus.out_valid, 1);
    chk("t1_elem_11_6_3", bus.data_out[8*335 +: 8], 8'h4F);
    chk("t1_elem_1_0_1", bus.data_out[8*29 +: 8], 8'd29);
    held = exp_read(m_rd, 3'd3);
    step();
    chk("t1_valid_drop", bus.out_valid, 0);
    chk("t1_hold", bus.data_out[127:0], held[127:0]);
    rd_release();
    check_status("t1_released");

    // 2: MLP layout, bank 1, B[a] = a % 251
    for (int w = 0; w < BANK_BYTES / 4; w++)
      ld_word(w, {8'((4*w+3)%251), 8'((4*w+2)%251), 8'((4*w+1)%251), 8'((4*w)%251)}, 4'hF);
    commit(1'b1);
    rd_start();
    rd_req(7);
    chk("t2_sub7_elem_0_0_0", bus.data_out[7:0], 8'd85);
    rd_req(0);
    chk("t2_sub0_elem_0_1_0", bus.data_out[8*4 +: 8], 8'd133);
    rd_release();
    check_status("t2_released");

    // 3: ring full, overrun, release, same-cycle commit + release
    for (int i = 0; i < 20; i++)
      ld_word($urandom_range(0, 83), $urandom, 4'($urandom_range(0, 15)));
    commit(1'b0);
    for (int i = 0; i < 20; i++)
      ld_word($urandom_range(0, BANK_BYTES/4 - 1), $urandom, 4'($urandom_range(0, 15)));
    commit(1'b0);
    check_status("t3_ring_full");
    ld_word(0, 32'hDEADBEEF, 4'hF);
    check_status("t3_overrun");
    rd_start();
    rd_req($urandom_range(0, 7));
    rd_release();
    check_status("t3_release");
    rd_start();
    bus.rd_req       = 1'b1;
    bus.rd_sub_cycle = 3'd0;
    bus.rd_release   = 1'b1;
    bus.mode         = 1'b0;
    bus.wr_commit    = 1'b1;
    step();
    check_status("t3_commit_and_release");
    rd_start();
    rd_req($urandom_range(0, 7));
    rd_release();

    // 4: per-bank layout, mode toggled between commits
    for (int i = 0; i < 30; i++)
      ld_word($urandom_range(0, 83), $urandom, 4'($urandom_range(0, 15)));
    commit(1'b0);
    for (int w = 0; w < BANK_BYTES / 4; w++)
      ld_word(w, $urandom, 4'hF);
    commit(1'b1);
    check_status("t4_two_full");
    rd_start();
    rd_req($urandom_range(0, 7));
    bus.rd_req       = 1'b1;
    bus.rd_sub_cycle = 3'($urandom_range(0, 7));
    bus.rd_release   = 1'b1;
    step();
    rd_start();
    for (int s = 0; s < 8; s++) rd_req(s);
    rd_release();
    check_status("t4_drained");

    // 5: load/capture byte collision
    old1 = m_mem[m_fill][1];
    old3 = m_mem[m_fill][3];
    cd = {$urandom, $urandom};
    cd[7:0] = 8'hAA;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = '0;
    bus.ld_data  = 32'h44332211;
    bus.ld_be    = 4'b0101;
    bus.cap_en   = 1'b1;
    bus.cap_col  = '0;
    bus.cap_data = cd;
    step();
    commit(1'b0);
    rd_start();
    rd_req(0);
    chk("t5_byte0_capture", bus.data_out[7:0], 8'hAA);
    chk("t5_byte1_kept", bus.data_out[15:8], old1);
    chk("t5_byte2_load", bus.data_out[23:16], 8'h33);
    chk("t5_byte3_kept", bus.data_out[31:24], old3);
    rd_release();

    // 6: reset mid-fill and mid-read
    for (int i = 0; i < 5; i++) ld_word(i, $urandom, 4'hF);
    commit(1'b0);
    rd_start();
    for (int i = 0; i < 5; i++) ld_word(i, $urandom, 4'hF);
    rd_req(0);
    step();
    check_status("t6_before_reset");
    #3;
    rst_n = 1'b0;
    m_reset();
    #1;
    check_status("t6_in_reset");
    chk("t6_in_reset_out_valid", bus.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_status("t6_after_reset");
    chk("t6_dbg_state", bus.dbg_state, 0);
    rd_req(0);
    check_status("t6_underrun");
    chk("t6_underrun_no_valid", bus.out_valid, 0);

    // All predicted reads must have been observed
    step();
    chk("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
